gate_response_checker: RTL and testbench



---
 rtl/gate_response_checker_pkg.sv | 26 ++
 rtl/gate_response_checker_ref_model.sv | 36 +++
 rtl/gate_response_checker.sv | 139 +++++++++++++
 tb/tb_gate_response_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_response_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_response_checker_pkg
// Description : Shared constants for the gate response checker: reference
//               function op-codes and checker FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_response_checker_pkg;

  // Reference function op-codes (Op input)
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ZERO = 3'b110;
  localparam logic [2:0] OP_ONE  = 3'b111;

  // Checker FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/gate_response_checker_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : gate_ref_model
// Description : Combinational reference gate. Returns the bit an ideal gate
//               of function op_i produces for input vector vec_i.
// Ports       : op_i       - reference function op-code
//               vec_i      - N_IN-bit input vector
//               expected_o - expected gate output
// Revision    : 1.0 - initial release
// ============================================================================
module gate_ref_model #(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op_i,
  input  logic [N_IN-1:0] vec_i,
  output logic            expected_o
);
  import gate_response_checker_pkg::*;

  always_comb begin
    expected_o = 1'b0;
    case (op_i)
      OP_AND:  expected_o = &vec_i;
      OP_OR:   expected_o = |vec_i;
      OP_XOR:  expected_o = ^vec_i;
      OP_NAND: expected_o = ~&vec_i;
      OP_NOR:  expected_o = ~|vec_i;
      OP_XNOR: expected_o = ~^vec_i;
      OP_ZERO: expected_o = 1'b0;
      OP_ONE:  expected_o = 1'b1;
      default: expected_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_response_checker
// Description : Sweeps all 2^N_IN input vectors of a gate under test, holds
//               each for SETTLE cycles, samples the gate result and compares
//               it with a reference function latched at Start. Reports a
//               saturating error count, the first failing vector and Pass.
// Ports       : Clk_i, Rst_i (sync, active-high), Start_i, Op_i[2:0],
//               DutResult_i -> DutIn_o[N_IN], Busy_o, Done_o, Pass_o,
//               ErrCount_o[CNT_W], FirstFailVec_o[N_IN], FirstFailValid_o
// Revision    : 1.0 - initial release
// ============================================================================
module gate_response_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic             Start_i,
  input  logic [2:0]       Op_i,
  input  logic             DutResult_i,
  output logic [N_IN-1:0]  DutIn_o,
  output logic             Busy_o,
  output logic             Done_o,
  output logic             Pass_o,
  output logic [CNT_W-1:0] ErrCount_o,
  output logic [N_IN-1:0]  FirstFailVec_o,
  output logic             FirstFailValid_o
);
  import gate_response_checker_pkg::*;

  // Settle counter needs at least one bit even when SETTLE==1
  localparam int                 c_SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_SET_W-1:0] c_RELOAD = c_SET_W'(SETTLE - 1);

  logic [1:0]         state_q,   state_d;
  logic [2:0]         op_q,      op_d;
  logic [N_IN-1:0]    vec_q,     vec_d;
  logic [c_SET_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0]   err_q,     err_d;
  logic [N_IN-1:0]    ffv_q,     ffv_d;
  logic               ffvalid_q, ffvalid_d;
  logic               pass_q,    pass_d;

  logic               w_expected;
  logic               w_mismatch;
  logic [CNT_W-1:0]   w_err_next;

  gate_ref_model #(
    .N_IN (N_IN)
  ) u_ref (
    .op_i       (op_q),
    .vec_i      (vec_q),
    .expected_o (w_expected)
  );

  assign w_mismatch = (DutResult_i != w_expected);
  // Count including the current sample; holds at all-ones once saturated
  assign w_err_next = (w_mismatch && (err_q != {CNT_W{1'b1}})) ?
                      (err_q + CNT_W'(1)) : err_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start_i) begin
          state_d   = ST_RUN;
          op_d      = Op_i;
          vec_d     = '0;
          cnt_d     = c_RELOAD;
          err_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - c_SET_W'(1);
        end else begin
          // Sample edge for the current vector
          err_d = w_err_next;
          if (w_mismatch && !ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
          if (vec_q != {N_IN{1'b1}}) begin
            vec_d = vec_q + N_IN'(1);
            cnt_d = c_RELOAD;
          end else begin
            state_d = ST_DONE;
            pass_d  = (w_err_next == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      vec_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
    end
  end

  assign DutIn_o          = vec_q;
  assign Busy_o           = (state_q == ST_RUN);
  assign Done_o           = (state_q == ST_DONE);
  assign Pass_o           = pass_q;
  assign ErrCount_o       = err_q;
  assign FirstFailVec_o   = ffv_q;
  assign FirstFailValid_o = ffvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_response_checker
// Description : Self-checking bench. Instance A (N_IN=2, SETTLE=1, CNT_W=8)
//               is checked every cycle against a sweep-level model; instance
//               B (N_IN=3, SETTLE=3, CNT_W=2) is checked against literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_response_checker;

  localparam int A_N  = 2;
  localparam int A_S  = 1;
  localparam int A_C  = 8;
  localparam int NV   = 1 << A_N;
  localparam int AMAX = (1 << A_C) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic           a_rst, a_start, a_res;
  logic [2:0]     a_op;
  logic [A_N-1:0] a_dutin, a_ffv;
  logic           a_busy, a_done, a_pass, a_ffvalid;
  logic [A_C-1:0] a_err;
  logic [2:0]     gate_op;  // function the emulated gate implements
  logic [NV-1:0]  flip;     // per-vector fault injection into the emulated gate

  // Ideal gate from first principles: count the ones in the vector
  function automatic logic gate_fn(input logic [2:0] op, input int v, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) if (((v >> i) & 1) == 1) ones++;
    case (op)
      3'd0: return ones == n;
      3'd1: return ones > 0;
      3'd2: return (ones % 2) == 1;
      3'd3: return ones != n;
      3'd4: return ones == 0;
      3'd5: return (ones % 2) == 0;
      3'd6: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign a_res = gate_fn(gate_op, int'(a_dutin), A_N) ^ flip[a_dutin];

  gate_response_checker #(.N_IN(A_N), .SETTLE(A_S), .CNT_W(A_C)) dut_a (
    .Clk_i(clk), .Rst_i(a_rst), .Start_i(a_start), .Op_i(a_op),
    .DutResult_i(a_res), .DutIn_o(a_dutin), .Busy_o(a_busy), .Done_o(a_done),
    .Pass_o(a_pass), .ErrCount_o(a_err), .FirstFailVec_o(a_ffv),
    .FirstFailValid_o(a_ffvalid));

  // ---------------- instance B ----------------
  logic           b_rst, b_start, b_res;
  logic [2:0]     b_op;
  logic [2:0]     b_dutin, b_ffv;
  logic           b_busy, b_done, b_pass, b_ffvalid;
  logic [1:0]     b_err;

  gate_response_checker #(.N_IN(3), .SETTLE(3), .CNT_W(2)) dut_b (
    .Clk_i(clk), .Rst_i(b_rst), .Start_i(b_start), .Op_i(b_op),
    .DutResult_i(b_res), .DutIn_o(b_dutin), .Busy_o(b_busy), .Done_o(b_done),
    .Pass_o(b_pass), .ErrCount_o(b_err), .FirstFailVec_o(b_ffv),
    .FirstFailValid_o(b_ffvalid));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- sweep-level model of instance A ----------------
  bit       m_run;
  int       m_k;
  logic [2:0] m_op;
  int       m_dutin, m_err, m_ffv;
  bit       m_busy, m_done, m_pass, m_ffvalid;

  always @(posedge clk) begin : model
    int v, cnt, first;
    if (a_rst) begin
      m_run = 0; m_k = 0; m_op = 0; m_dutin = 0; m_err = 0; m_ffv = 0;
      m_busy = 0; m_done = 0; m_pass = 0; m_ffvalid = 0;
    end else if (a_start && !m_run) begin
      m_run = 1; m_k = 0; m_op = a_op; m_dutin = 0; m_err = 0; m_ffv = 0;
      m_busy = 1; m_done = 0; m_pass = 0; m_ffvalid = 0;
    end else if (m_run) begin
      m_k++;
      if (m_k % A_S == 0) begin
        // Vector v is sampled SETTLE*(v+1) edges after the start edge
        v = m_k / A_S - 1;
        cnt = 0; first = -1;
        for (int u = 0; u <= v; u++)
          if ((gate_fn(gate_op, u, A_N) ^ flip[u]) != gate_fn(m_op, u, A_N)) begin
            cnt++;
            if (first < 0) first = u;
          end
        m_err     = (cnt > AMAX) ? AMAX : cnt;
        m_ffvalid = (first >= 0);
        m_ffv     = (first >= 0) ? first : 0;
        if (v == NV - 1) begin
          m_run = 0; m_busy = 0; m_done = 1; m_pass = (cnt == 0);
        end else begin
          m_dutin = v + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_dutin",   32'(a_dutin),   32'(m_dutin));
    chk("cyc_busy",    32'(a_busy),    32'(m_busy));
    chk("cyc_done",    32'(a_done),    32'(m_done));
    chk("cyc_pass",    32'(a_pass),    32'(m_pass));
    chk("cyc_err",     32'(a_err),     32'(m_err));
    chk("cyc_ffv",     32'(a_ffv),     32'(m_ffv));
    chk("cyc_ffvalid", 32'(a_ffvalid), 32'(m_ffvalid));
  end

  // ---------------- stimulus ----------------
  int seq [0:63];

  // Start a sweep on A; n returns the edges from the start edge to Done.
  task automatic sweep_a(input logic [2:0] op, input logic [2:0] gop,
                         input logic [NV-1:0] fl, input bit repulse,
                         input bit noise, output int n);
    @(negedge clk);
    a_op = op; gate_op = gop; flip = fl; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    seq[0] = int'(a_dutin);
    n = 0;
    while (n < 200) begin
      @(posedge clk); n++; #1;
      if (n < 64) seq[n] = int'(a_dutin);
      if (a_done) break;
      if (repulse && n == 1) a_start = 1'b1;
      if (repulse && n == 2) a_start = 1'b0;
      if (noise) a_op = 3'($urandom_range(7));
    end
    a_start = 1'b0;
    if (!a_done) chk("done_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, k;
    a_rst = 1; a_start = 0; a_op = 0; gate_op = 0; flip = '0;
    b_rst = 1; b_start = 0; b_op = 3'b111; b_res = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_err",  32'(a_err), 0);
    chk("rst_dutin", 32'(a_dutin), 0);
    chk("rst_ffvalid", 32'(a_ffvalid), 0);
    chk("rstb_done", 32'(b_done), 0);
    a_rst = 0; b_rst = 0;

    // Correct AND gate
    sweep_a(3'b000, 3'b000, '0, 0, 0, n);
    chk("and_latency", n, 4);
    chk("and_seq0", seq[0], 0);
    chk("and_seq1", seq[1], 1);
    chk("and_seq2", seq[2], 2);
    chk("and_seq3", seq[3], 3);
    chk("and_pass", 32'(a_pass), 1);
    chk("and_err", 32'(a_err), 0);
    chk("and_ffvalid", 32'(a_ffvalid), 0);

    // OR gate checked as AND (restart from DONE)
    sweep_a(3'b000, 3'b001, '0, 0, 0, n);
    chk("or_err", 32'(a_err), 2);
    chk("or_ffv", 32'(a_ffv), 1);
    chk("or_ffvalid", 32'(a_ffvalid), 1);
    chk("or_pass", 32'(a_pass), 0);

    // Stuck-at-1 output
    sweep_a(3'b011, 3'b111, '0, 0, 0, n);
    chk("s1nand_err", 32'(a_err), 1);
    chk("s1nand_ffv", 32'(a_ffv), 3);
    sweep_a(3'b000, 3'b111, '0, 0, 0, n);
    chk("s1and_err", 32'(a_err), 3);
    chk("s1and_ffv", 32'(a_ffv), 0);

    // Reset one edge after DutIn=2 appears
    @(negedge clk);
    a_op = 3'b000; gate_op = 3'b000; flip = '0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    k = 0;
    while (k < 50) begin
      @(posedge clk); k++; #1;
      if (a_dutin == 2'd2) break;
    end
    if (a_dutin != 2'd2) chk("rst_wait_timeout", 0, 1);
    @(negedge clk); a_rst = 1'b1;
    @(negedge clk); a_rst = 1'b0;
    chk("abort_busy", 32'(a_busy), 0);
    chk("abort_done", 32'(a_done), 0);
    chk("abort_dutin", 32'(a_dutin), 0);
    sweep_a(3'b000, 3'b000, '0, 0, 0, n);
    chk("post_abort_pass", 32'(a_pass), 1);

    // Start while busy is ignored
    sweep_a(3'b010, 3'b010, '0, 1, 0, n);
    chk("repulse_latency", n, 4);
    chk("repulse_pass", 32'(a_pass), 1);

    // Rst and Start together: Rst wins
    @(negedge clk); a_rst = 1'b1; a_start = 1'b1;
    @(negedge clk); a_rst = 1'b0; a_start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 32'(a_busy), 0);

    // Randomized sweeps, with mid-sweep Op noise and Start re-pulses
    for (int it = 0; it < 40; it++) begin
      sweep_a(3'($urandom_range(7)), 3'($urandom_range(7)), NV'($urandom),
              1'($urandom_range(1)), 1'($urandom_range(1)), n);
      chk("rnd_latency", n, NV * A_S);
    end

    // Instance B: constant-0 gate checked against const-1
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    k = 0;
    while (k < 40) begin
      @(posedge clk); k++; #1;
      case (k)
        2:  chk("b_vec_k2", 32'(b_dutin), 0);
        3:  chk("b_vec_k3", 32'(b_dutin), 1);
        5:  chk("b_vec_k5", 32'(b_dutin), 1);
        6:  chk("b_vec_k6", 32'(b_dutin), 2);
        23: begin
          chk("b_vec_k23", 32'(b_dutin), 7);
          chk("b_busy_k23", 32'(b_busy), 1);
        end
        default: ;
      endcase
      if (b_done) break;
    end
    chk("b_latency", k, 24);
    chk("b_err", 32'(b_err), 3);
    chk("b_ffv", 32'(b_ffv), 0);
    chk("b_ffvalid", 32'(b_ffvalid), 1);
    chk("b_pass", 32'(b_pass), 0);
    chk("b_dutin_hold", 32'(b_dutin), 7);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
